sprite_motion_engine: RTL and testbench

SPRITE_MOTION_ENGINE -- requirements
Module: sprite_motion_engine

---
 rtl/sprite_pkg.sv | 60 ++++++
 rtl/sprite_axis_step.sv | 44 ++++
 rtl/sprite_motion_engine.sv | 188 ++++++++++++++++++
 tb/tb_sprite_motion_engine.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion engine.
//   sprite_t  : packed {x, y, right, bottom} screen rectangle (right/bottom exclusive)
//   vel_t     : default-width signed per-axis velocity
//   state_t   : pass sequencer states
//   DEFAULT_SPRITES : reset set, entry 0 = player, 1 = enemy, 2 = ball, rest spare
package sprite_pkg;

  localparam int SCREEN_H_RES = 640;
  localparam int SCREEN_V_RES = 480;
  localparam int COORD_W      = 10;

  localparam int N_SPRITES = 3;
  localparam int SPEED_W   = 5;
  localparam int BORDER    = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t right;
    coord_t bottom;
  } sprite_t;

  typedef logic signed [SPEED_W-1:0] vel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_CHECK,
    ST_COMMIT
  } state_t;

  function automatic sprite_t mk_sprite(int x, int y, int w, int h);
    sprite_t s;
    s.x      = COORD_W'(x);
    s.y      = COORD_W'(y);
    s.right  = COORD_W'(x + w);
    s.bottom = COORD_W'(y + h);
    return s;
  endfunction

  // Strict inequalities: rectangles that only share an edge do not overlap.
  function automatic logic sprites_overlap(sprite_t a, sprite_t b);
    return (a.x < b.right) && (b.x < a.right) &&
           (a.y < b.bottom) && (b.y < a.bottom);
  endfunction

  localparam sprite_t [7:0] DEFAULT_SPRITES = {
    mk_sprite(520,  40,  8,  8),
    mk_sprite(440,  40,  8,  8),
    mk_sprite(360,  40,  8,  8),
    mk_sprite(280,  40,  8,  8),
    mk_sprite(200,  40,  8,  8),
    mk_sprite(315, 235, 10, 10),
    mk_sprite( 20, 215, 10, 50),
    mk_sprite(610, 215, 10, 50)
  };

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis motion step: add velocity, clamp to [lo, hi], bounce on contact.
//   pos/vel      : current coordinate and signed velocity
//   lo/hi        : inclusive limits for the leading coordinate (signed, PW+1 bits)
//   pos_nxt/vel_nxt : stepped coordinate and (possibly negated) velocity
//   wall         : limit reached or exceeded this step
module sprite_axis_step #(
  parameter int PW = 10,
  parameter int VW = 5
) (
  input  logic [PW-1:0]        pos,
  input  logic [VW-1:0]        vel,
  input  logic signed [PW:0]   lo,
  input  logic signed [PW:0]   hi,
  output logic [PW-1:0]        pos_nxt,
  output logic [VW-1:0]        vel_nxt,
  output logic                 wall
);

  logic signed [PW:0] vel_ext;
  logic signed [PW:0] sum;

  always_comb begin
    vel_ext = {{(PW+1-VW){vel[VW-1]}}, vel};
    sum     = $signed({1'b0, pos}) + vel_ext;
    pos_nxt = pos;
    vel_nxt = vel;
    wall    = 1'b0;
    // A stationary sprite never bounces, even if it sits on a limit.
    if (vel != '0) begin
      if (sum <= lo) begin
        pos_nxt = lo[PW-1:0];
        vel_nxt = -vel;
        wall    = 1'b1;
      end else if (sum >= hi) begin
        pos_nxt = hi[PW-1:0];
        vel_nxt = -vel;
        wall    = 1'b1;
      end else begin
        pos_nxt = sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/sprite_motion_engine.sv
// Per-frame sprite mover: on frame_tick_i steps every sprite by its velocity
// (bouncing off the screen margin), checks all pairs for overlap, then
// commits positions and flags atomically.
//   clk_i, rst_i      : clock, async active-high reset
//   frame_tick_i      : start a pass (ignored and flagged as overrun while busy)
//   load_*            : write one sprite's position/velocity while idle
//   sprites_o         : committed positions
//   wall_hit_o/hit_o  : per-sprite border / collision flags of the last pass
//   busy_o, done_o, overrun_o : pass status
module sprite_motion_engine #(
  parameter int N_SPRITES = sprite_pkg::N_SPRITES,
  parameter int SPEED_W   = sprite_pkg::SPEED_W,
  parameter int BORDER    = sprite_pkg::BORDER,
  parameter sprite_pkg::sprite_t [N_SPRITES-1:0] INIT_SPRITES =
    sprite_pkg::DEFAULT_SPRITES[N_SPRITES-1:0],
  parameter logic [N_SPRITES-1:0][SPEED_W-1:0] INIT_VX = '0,
  parameter logic [N_SPRITES-1:0][SPEED_W-1:0] INIT_VY = '0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  frame_tick_i,
  input  logic                                  load_i,
  input  logic [$clog2(N_SPRITES)-1:0]          load_idx_i,
  input  sprite_pkg::sprite_t                   load_sprite_i,
  input  logic [SPEED_W-1:0]                    load_vx_i,
  input  logic [SPEED_W-1:0]                    load_vy_i,
  output sprite_pkg::sprite_t [N_SPRITES-1:0]   sprites_o,
  output logic [N_SPRITES-1:0]                  wall_hit_o,
  output logic [N_SPRITES-1:0]                  hit_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  overrun_o
);

  import sprite_pkg::*;

  localparam int IW = $clog2(N_SPRITES);
  localparam int CW = COORD_W;

  state_t state, state_nxt;

  // Working set: all motion and collision work happens here; sprites_o only
  // changes when a pass finishes.
  sprite_t [N_SPRITES-1:0]             wrk;
  logic [N_SPRITES-1:0][SPEED_W-1:0]   vx, vy;
  logic [N_SPRITES-1:0]                wall, hit, hit_nxt;

  sprite_t [N_SPRITES-1:0]             spr_q;
  logic [N_SPRITES-1:0]                wall_q, hit_q;
  logic                                overrun_q;

  logic [IW-1:0] idx, pi, pj;
  logic          load_ok, upd_last, pair_last;

  // Step datapath for the sprite currently addressed by idx.
  sprite_t            cur, step_spr;
  coord_t             w_cur, h_cur, xn, yn;
  logic [SPEED_W-1:0] vx_n, vy_n;
  logic               wall_x, wall_y;
  logic signed [CW:0] lo, hi_x, hi_y;

  assign load_ok   = load_i && ({1'b0, load_idx_i} < (IW+1)'(N_SPRITES));
  assign upd_last  = (idx == IW'(N_SPRITES-1));
  assign pair_last = (pi == IW'(N_SPRITES-2)) && (pj == IW'(N_SPRITES-1));

  always_comb begin
    cur   = wrk[idx];
    w_cur = cur.right - cur.x;
    h_cur = cur.bottom - cur.y;
    lo    = signed'((CW+1)'(BORDER));
    hi_x  = signed'((CW+1)'(SCREEN_H_RES - BORDER)) - signed'({1'b0, w_cur});
    hi_y  = signed'((CW+1)'(SCREEN_V_RES - BORDER)) - signed'({1'b0, h_cur});
  end

  sprite_axis_step #(.PW(CW), .VW(SPEED_W)) u_step_x (
    .pos(cur.x), .vel(vx[idx]), .lo(lo), .hi(hi_x),
    .pos_nxt(xn), .vel_nxt(vx_n), .wall(wall_x)
  );

  sprite_axis_step #(.PW(CW), .VW(SPEED_W)) u_step_y (
    .pos(cur.y), .vel(vy[idx]), .lo(lo), .hi(hi_y),
    .pos_nxt(yn), .vel_nxt(vy_n), .wall(wall_y)
  );

  always_comb begin
    step_spr.x      = xn;
    step_spr.y      = yn;
    step_spr.right  = xn + w_cur;
    step_spr.bottom = yn + h_cur;
  end

  always_comb begin
    hit_nxt = hit;
    if (sprites_overlap(wrk[pi], wrk[pj])) begin
      hit_nxt[pi] = 1'b1;
      hit_nxt[pj] = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (frame_tick_i) state_nxt = ST_UPDATE;
      ST_UPDATE: if (upd_last)     state_nxt = ST_CHECK;
      ST_CHECK:  if (pair_last)    state_nxt = ST_COMMIT;
      ST_COMMIT:                   state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state != ST_IDLE);
    done_o = (state == ST_COMMIT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrk       <= INIT_SPRITES;
      vx        <= INIT_VX;
      vy        <= INIT_VY;
      wall      <= '0;
      hit       <= '0;
      spr_q     <= INIT_SPRITES;
      wall_q    <= '0;
      hit_q     <= '0;
      overrun_q <= 1'b0;
      idx       <= '0;
      pi        <= '0;
      pj        <= IW'(1);
    end else begin
      case (state)
        ST_IDLE: begin
          // Load lands before the pass starts, so a same-cycle tick uses it.
          if (load_ok) begin
            wrk[load_idx_i] <= load_sprite_i;
            vx[load_idx_i]  <= load_vx_i;
            vy[load_idx_i]  <= load_vy_i;
          end
          if (frame_tick_i) begin
            wall <= '0;
            hit  <= '0;
            idx  <= '0;
            pi   <= '0;
            pj   <= IW'(1);
          end
        end
        ST_UPDATE: begin
          wrk[idx]  <= step_spr;
          vx[idx]   <= vx_n;
          vy[idx]   <= vy_n;
          wall[idx] <= wall_x | wall_y;
          idx       <= idx + IW'(1);
        end
        ST_CHECK: begin
          hit <= hit_nxt;
          if (pj == IW'(N_SPRITES-1)) begin
            pi <= pi + IW'(1);
            pj <= pi + IW'(2);
          end else begin
            pj <= pj + IW'(1);
          end
          // Publish on the last pair so outputs are already valid while done_o is high.
          if (pair_last) begin
            spr_q  <= wrk;
            wall_q <= wall;
            hit_q  <= hit_nxt;
          end
        end
        default: ;
      endcase
      if (frame_tick_i && state != ST_IDLE) overrun_q <= 1'b1;
    end
  end

  assign sprites_o  = spr_q;
  assign wall_hit_o = wall_q;
  assign hit_o      = hit_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_sprite_motion_engine.sv
module tb_sprite_motion_engine;
  import sprite_pkg::*;

  logic              clk, rst, frame_tick, load;
  logic [1:0]        load_idx;
  sprite_t           load_sprite;
  logic [4:0]        load_vx, load_vy;
  sprite_t [2:0]     sprites;
  logic [2:0]        wall_hit, hit;
  logic              busy, done, overrun;

  int checks = 0;
  int errors = 0;

  sprite_motion_engine dut (
    .clk_i(clk), .rst_i(rst), .frame_tick_i(frame_tick),
    .load_i(load), .load_idx_i(load_idx), .load_sprite_i(load_sprite),
    .load_vx_i(load_vx), .load_vy_i(load_vy),
    .sprites_o(sprites), .wall_hit_o(wall_hit), .hit_o(hit),
    .busy_o(busy), .done_o(done), .overrun_o(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sprite_t spr(int x, int y, int r, int b);
    sprite_t s;
    s.x = 10'(x); s.y = 10'(y); s.right = 10'(r); s.bottom = 10'(b);
    return s;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_load(input int idx, input sprite_t s, input int vx, input int vy);
    load = 1'b1; load_idx = 2'(idx); load_sprite = s;
    load_vx = 5'(vx); load_vy = 5'(vy);
  endtask

  // Pulses frame_tick (with any load already set up) and waits for done_o;
  // lat counts cycles from the tick to the cycle done_o is seen.
  task automatic run_pass(output int lat);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0; load = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (sprites !== {spr(315,235,325,245), spr(20,215,30,265), spr(610,215,620,265)}) begin
      errors++; $display("FAIL reset_sprites: got %h exp init set", sprites); end
    checks++; if ({busy, done, overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_status: got %b exp 000", {busy, done, overrun}); end
    checks++; if ({wall_hit, hit} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b exp 0", {wall_hit, hit}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_move();
    int lat;
    set_load(2, spr(315,235,325,245), 4, 1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0; load = 1'b0;
    checks++; if ({busy, done} !== 2'b10) begin
      errors++; $display("FAIL move_busy_t1: got %b exp 10", {busy, done}); end
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin step(); lat++; end
    checks++; if (lat !== 7) begin
      errors++; $display("FAIL move_latency: got %0d exp 7", lat); end
    checks++; if (sprites[2] !== spr(319,236,329,246)) begin
      errors++; $display("FAIL move_ball: got %h exp %h", sprites[2], spr(319,236,329,246)); end
    checks++; if ({wall_hit, hit} !== 6'b0) begin
      errors++; $display("FAIL move_flags: got %b exp 0", {wall_hit, hit}); end
    step();
    checks++; if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL move_idle: got %b exp 00", {busy, done}); end
  endtask

  task automatic test_wall_x();
    int lat;
    set_load(2, spr(618,100,628,110), 4, 0);
    run_pass(lat);
    checks++; if (sprites[2] !== spr(620,100,630,110)) begin
      errors++; $display("FAIL wall_x_clamp: got %h exp %h", sprites[2], spr(620,100,630,110)); end
    checks++; if (wall_hit !== 3'b100 || hit !== 3'b000) begin
      errors++; $display("FAIL wall_x_flag: got %b/%b exp 100/000", wall_hit, hit); end
    step();
    run_pass(lat);
    checks++; if (sprites[2] !== spr(616,100,626,110)) begin
      errors++; $display("FAIL wall_x_bounce: got %h exp %h", sprites[2], spr(616,100,626,110)); end
    checks++; if (wall_hit !== 3'b000) begin
      errors++; $display("FAIL wall_x_clear: got %b exp 000", wall_hit); end
    step();
  endtask

  task automatic test_wall_y();
    int lat;
    // Lands exactly on the top limit: no overshoot but still bounces.
    set_load(2, spr(315,13,325,23), 0, -3);
    run_pass(lat);
    checks++; if (sprites[2] !== spr(315,10,325,20) || wall_hit !== 3'b100) begin
      errors++; $display("FAIL wall_y_exact: got %h/%b exp %h/100", sprites[2], wall_hit, spr(315,10,325,20)); end
    step();
    run_pass(lat);
    checks++; if (sprites[2] !== spr(315,13,325,23) || wall_hit !== 3'b000) begin
      errors++; $display("FAIL wall_y_rebound: got %h/%b exp %h/000", sprites[2], wall_hit, spr(315,13,325,23)); end
    step();
    // Overshoots the top limit and is clamped.
    set_load(2, spr(315,12,325,22), 0, -3);
    run_pass(lat);
    checks++; if (sprites[2] !== spr(315,10,325,20) || wall_hit !== 3'b100) begin
      errors++; $display("FAIL wall_y_clamp: got %h/%b exp %h/100", sprites[2], wall_hit, spr(315,10,325,20)); end
    step();
  endtask

  task automatic test_zero_vel();
    int lat;
    set_load(2, spr(620,100,630,110), 0, 0);
    run_pass(lat);
    checks++; if (sprites[2] !== spr(620,100,630,110) || wall_hit !== 3'b000) begin
      errors++; $display("FAIL zero_vel: got %h/%b exp %h/000", sprites[2], wall_hit, spr(620,100,630,110)); end
    step();
  endtask

  task automatic test_overlap();
    int lat;
    set_load(2, spr(605,230,615,240), 0, 0);
    run_pass(lat);
    checks++; if (hit !== 3'b101) begin
      errors++; $display("FAIL overlap_hit: got %b exp 101", hit); end
    step();
    set_load(2, spr(600,230,610,240), 0, 0);
    run_pass(lat);
    checks++; if (hit !== 3'b000) begin
      errors++; $display("FAIL overlap_touch: got %b exp 000", hit); end
    step();
  endtask

  task automatic test_overrun();
    int lat;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step(); step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    lat = 4;
    checks++; if ({busy, overrun} !== 2'b11) begin
      errors++; $display("FAIL overrun_set: got %b exp 11", {busy, overrun}); end
    while (done !== 1'b1 && lat < 40) begin step(); lat++; end
    checks++; if (lat !== 7) begin
      errors++; $display("FAIL overrun_latency: got %0d exp 7", lat); end
    step(); step();
    checks++; if ({busy, overrun} !== 2'b01) begin
      errors++; $display("FAIL overrun_sticky: got %b exp 01", {busy, overrun}); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    checks++; if ({busy, done, overrun} !== 3'b000) begin
      errors++; $display("FAIL midreset_status: got %b exp 000", {busy, done, overrun}); end
    checks++; if (sprites !== {spr(315,235,325,245), spr(20,215,30,265), spr(610,215,620,265)}) begin
      errors++; $display("FAIL midreset_sprites: got %h exp init set", sprites); end
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen = 1;
    end
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL midreset_nodone: got %0d exp 0", seen); end
  endtask

  task automatic test_load();
    int lat;
    set_load(1, spr(30,100,40,150), 0, -3);
    frame_tick = 1'b1; step(); frame_tick = 1'b0; load = 1'b0;
    step();
    // Load attempted while busy must not take effect.
    set_load(1, spr(200,300,210,310), 0, 5);
    step(); step();
    load = 1'b0;
    lat = 4;
    while (done !== 1'b1 && lat < 40) begin step(); lat++; end
    checks++; if (sprites[1] !== spr(30,97,40,147)) begin
      errors++; $display("FAIL load_tick: got %h exp %h", sprites[1], spr(30,97,40,147)); end
    step();
    run_pass(lat);
    checks++; if (sprites[1] !== spr(30,94,40,144)) begin
      errors++; $display("FAIL load_busy_ignored: got %h exp %h", sprites[1], spr(30,94,40,144)); end
    step();
    // Load alone is not visible until the next commit.
    set_load(1, spr(50,100,60,150), 0, 0);
    step(); load = 1'b0; step();
    checks++; if (sprites[1] !== spr(30,94,40,144)) begin
      errors++; $display("FAIL load_hidden: got %h exp %h", sprites[1], spr(30,94,40,144)); end
    run_pass(lat);
    checks++; if (sprites[1] !== spr(50,100,60,150)) begin
      errors++; $display("FAIL load_commit: got %h exp %h", sprites[1], spr(50,100,60,150)); end
    step();
    // Out-of-range index is dropped.
    set_load(3, spr(100,100,110,110), 2, 2);
    run_pass(lat);
    checks++; if (sprites !== {spr(315,235,325,245), spr(50,100,60,150), spr(610,215,620,265)}) begin
      errors++; $display("FAIL load_bad_idx: got %h exp unchanged set", sprites); end
    step();
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; load = 1'b0; load_idx = '0;
    load_sprite = '0; load_vx = '0; load_vy = '0;
    test_reset();
    test_move();
    test_wall_x();
    test_wall_y();
    test_zero_vel();
    test_overlap();
    test_overrun();
    test_reset_mid();
    test_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
